// File: rtl/gate_sync_strobe.sv
// Gate-pin front end: synchronises data and gate pins, debounces the gate, and emits a load strobe with captured data.
// Latency: CE rises SYNC_STAGES+DEBOUNCE_CYCLES edges after GATE is first sampled high; O and LEVEL are registered.
// Backpressure: none; CE is a single-cycle strobe and downstream loaders must accept it on the cycle it is high.
module gate_sync_strobe #(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic [WIDTH-1:0] I,
    input  logic             GATE,
    output logic [WIDTH-1:0] O,
    output logic             CE,
    output logic             LEVEL
);

    // The counter only has to reach DEBOUNCE_CYCLES-1 before the ARM state is left, so it never wraps.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_LOW    = 2'd0,
        ST_ARM_HI = 2'd1,
        ST_HIGH   = 2'd2,
        ST_ARM_LO = 2'd3
    } state_t;

    logic [WIDTH-1:0]       data_sync [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] gate_sync;
    logic [WIDTH-1:0]       data_s;
    logic                   gate_s;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;

    assign data_s = data_sync[SYNC_STAGES-1];
    assign gate_s = gate_sync[SYNC_STAGES-1];

    // Synchroniser chains for the asynchronous data and gate pins.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            gate_sync <= '0;
            for (int k = 0; k < SYNC_STAGES; k++) begin
                data_sync[k] <= '0;
            end
        end else begin
            gate_sync    <= {gate_sync[SYNC_STAGES-2:0], GATE};
            data_sync[0] <= I;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                data_sync[k] <= data_sync[k-1];
            end
        end
    end

    // Debounce FSM with registered level, strobe and captured data word.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state <= ST_LOW;
            cnt   <= '0;
            O     <= '0;
            CE    <= 1'b0;
            LEVEL <= 1'b0;
        end else begin
            CE <= 1'b0;
            case (state)
                ST_LOW: begin
                    if (gate_s) begin
                        state <= ST_ARM_HI;
                        cnt   <= '0;
                    end
                end
                ST_ARM_HI: begin
                    if (!gate_s) begin
                        // Glitch shorter than the debounce window: back to idle, no strobe.
                        state <= ST_LOW;
                    end else if (cnt == CNT_LAST) begin
                        state <= ST_HIGH;
                        LEVEL <= 1'b1;
                        CE    <= 1'b1;
                        O     <= data_s;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_HIGH: begin
                    if (!gate_s) begin
                        state <= ST_ARM_LO;
                        cnt   <= '0;
                    end
                end
                ST_ARM_LO: begin
                    if (gate_s) begin
                        // Short release: stay logically high and do not retrigger.
                        state <= ST_HIGH;
                    end else if (cnt == CNT_LAST) begin
                        state <= ST_LOW;
                        LEVEL <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_LOW;
                    LEVEL <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_sync_strobe.sv
// Self-checking bench for gate_sync_strobe: directed scenarios plus randomized bouncy gate traffic.
// Latency: outputs are compared 1 time unit after each rising edge against a run-length debounce model.
// Backpressure: not applicable; the bench drives inputs every cycle.
module tb_gate_sync_strobe;

    localparam int W = 4;
    localparam int S = 2;
    localparam int D = 16;

    logic         CLK;
    logic         RESETN;
    logic [W-1:0] I;
    logic         GATE;
    logic [W-1:0] O;
    logic         CE;
    logic         LEVEL;

    int n_cmp = 0;
    int n_bad = 0;
    int ce_seen = 0;

    // Reference model: inputs pass through an S-deep delay line; the debounced level flips
    // once D+1 consecutive delayed gate samples disagree with it; a flip to 1 strobes CE and
    // captures the delayed data.
    logic         gq [$];
    logic [W-1:0] dq [$];
    logic         m_lvl;
    int           m_run;
    logic [W-1:0] m_o;
    logic         m_ce;

    gate_sync_strobe #(.WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut (
        .CLK    (CLK),
        .RESETN (RESETN),
        .I      (I),
        .GATE   (GATE),
        .O      (O),
        .CE     (CE),
        .LEVEL  (LEVEL)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_edge(input logic g, input logic [W-1:0] d, input logic r);
        logic         g_used;
        logic [W-1:0] d_used;
        if (!r) begin
            gq.delete();
            dq.delete();
            for (int k = 0; k < S; k++) begin
                gq.push_back(1'b0);
                dq.push_back('0);
            end
            m_lvl = 1'b0;
            m_run = 0;
            m_o   = '0;
            m_ce  = 1'b0;
        end else begin
            g_used = gq[S-1];
            d_used = dq[S-1];
            void'(gq.pop_back());
            void'(dq.pop_back());
            gq.push_front(g);
            dq.push_front(d);
            m_ce = 1'b0;
            if (g_used != m_lvl) m_run++;
            else                 m_run = 0;
            if (m_run == D + 1) begin
                m_lvl = ~m_lvl;
                m_run = 0;
                if (m_lvl) begin
                    m_ce = 1'b1;
                    m_o  = d_used;
                end
            end
        end
    endtask

    // One clock: drive inputs while the clock is low, advance the model at the edge, compare after it.
    task automatic step(input logic g, input logic [W-1:0] d, input logic r);
        GATE   = g;
        I      = d;
        RESETN = r;
        @(posedge CLK);
        model_edge(g, d, r);
        #1;
        chk("ce",    {31'd0, CE},      {31'd0, m_ce});
        chk("level", {31'd0, LEVEL},   {31'd0, m_lvl});
        chk("o",     {28'd0, O},       {28'd0, m_o});
        if (CE === 1'b1) ce_seen++;
        @(negedge CLK);
    endtask

    task automatic hold(input logic g, input logic [W-1:0] d, input int n);
        for (int k = 0; k < n; k++) step(g, d, 1'b1);
    endtask

    // Steps with fixed inputs until CE shows; at is the step index (0 = first step driven) or -1.
    task automatic measure_ce(input logic g, input logic [W-1:0] d, input int maxc, output int at);
        at = -1;
        for (int k = 0; k < maxc; k++) begin
            step(g, d, 1'b1);
            if (CE === 1'b1) begin
                at = k;
                break;
            end
        end
    endtask

    initial begin
        int at;
        int ce0;
        int run_len;
        logic g;

        GATE   = 1'b0;
        I      = '0;
        RESETN = 1'b0;
        @(negedge CLK);

        // 1: reset held with active inputs, then release.
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 4'hF, 1'b0);
            chk("rst_o",     {28'd0, O},     32'd0);
            chk("rst_ce",    {31'd0, CE},    32'd0);
            chk("rst_level", {31'd0, LEVEL}, 32'd0);
        end
        measure_ce(1'b1, 4'hF, 40, at);
        chk("t1_latency", at, 32'd18);
        chk("t1_o", {28'd0, O}, 32'hF);
        step(1'b1, 4'hF, 1'b1);
        chk("t1_ce_fall", {31'd0, CE}, 32'd0);

        // 2: clean press after a full release.
        hold(1'b0, 4'h0, 25);
        chk("t2_idle_level", {31'd0, LEVEL}, 32'd0);
        measure_ce(1'b1, 4'hA, 40, at);
        chk("t2_latency", at, 32'd18);
        chk("t2_level", {31'd0, LEVEL}, 32'd1);
        chk("t2_o", {28'd0, O}, 32'hA);

        // 3: bounce during the press restarts the debounce.
        hold(1'b0, 4'h0, 25);
        ce0 = ce_seen;
        hold(1'b1, 4'h6, 10);
        hold(1'b0, 4'h6, 1);
        chk("t3_no_early_ce", ce_seen - ce0, 32'd0);
        measure_ce(1'b1, 4'h6, 40, at);
        chk("t3_latency", at, 32'd18);

        // 4: short release does not retrigger; full release plus new press does, once.
        ce0 = ce_seen;
        hold(1'b0, 4'h9, 5);
        hold(1'b1, 4'h9, 30);
        chk("t4_level_kept", {31'd0, LEVEL}, 32'd1);
        chk("t4_no_retrigger", ce_seen - ce0, 32'd0);
        hold(1'b0, 4'h9, 25);
        chk("t4_released", {31'd0, LEVEL}, 32'd0);
        ce0 = ce_seen;
        hold(1'b1, 4'h5, 40);
        chk("t4_one_ce", ce_seen - ce0, 32'd1);
        chk("t4_o", {28'd0, O}, 32'h5);

        // 5: data changes between strobes stay invisible.
        hold(1'b0, 4'h0, 25);
        measure_ce(1'b1, 4'h3, 40, at);
        chk("t5_latency", at, 32'd18);
        ce0 = ce_seen;
        for (int v = 0; v < 16; v++) begin
            step(1'b1, 4'(v), 1'b1);
            chk("t5_o_hold", {28'd0, O}, 32'h3);
        end
        chk("t5_no_ce", ce_seen - ce0, 32'd0);

        // 6: reset in the middle of the press debounce kills that press.
        hold(1'b0, 4'h0, 25);
        ce0 = ce_seen;
        hold(1'b1, 4'hC, 10);
        step(1'b0, 4'hC, 1'b0);
        chk("t6_level", {31'd0, LEVEL}, 32'd0);
        chk("t6_ce", {31'd0, CE}, 32'd0);
        hold(1'b0, 4'hC, 40);
        chk("t6_no_ce", ce_seen - ce0, 32'd0);

        // Gate toggling every cycle never strobes.
        ce0 = ce_seen;
        for (int k = 0; k < 60; k++) step(k[0], 4'($urandom), 1'b1);
        chk("toggle_no_ce", ce_seen - ce0, 32'd0);

        // Randomized bouncy gate with random data and occasional resets.
        g = 1'b0;
        for (int seg = 0; seg < 120; seg++) begin
            g = ~g;
            run_len = $urandom_range(1, 2 * D + 8);
            for (int k = 0; k < run_len; k++) begin
                step(g, 4'($urandom), ($urandom_range(0, 299) != 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
